lm_sm_sequencer: RTL and testbench

- Sits between the fetch/decode pipeline register and the decode stage.
- Expands each LM/SM multi-register instruction into a sequence of single-register LW/SW micro-ops, one per set bit in the register list.
- Holds fetch stalled while the expansion runs.
- Every other instruction passes through with one cycle of latency, so decode never sees LM/SM.

---
 rtl/lm_sm_sequencer_pkg.sv | 15 +
 rtl/lm_sm_sequencer_lsb_pick8.sv | 25 ++
 rtl/lm_sm_sequencer.sv | 167 ++++++++++++++++
 tb/tb_lm_sm_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/lm_sm_sequencer_pkg.sv
// Shared constants and state encoding for the LM/SM micro-op sequencer.
package lm_sm_sequencer_pkg;

  localparam logic [15:0] NOP_WORD = 16'hF000;
  localparam logic [3:0]  OP_LM    = 4'b0110;
  localparam logic [3:0]  OP_SM    = 4'b0111;
  localparam logic [3:0]  OP_LW    = 4'b0100;
  localparam logic [3:0]  OP_SW    = 4'b0101;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } state_t;

endpackage

// File: rtl/lm_sm_sequencer_lsb_pick8.sv
// Combinational lowest-set-bit finder over an 8-bit register list.
module lsb_pick8 (
  input  logic [7:0] mask,
  output logic [2:0] idx,
  output logic [7:0] clr,
  output logic       multi
);

  // Bit-select patterns: row b marks every position whose index has bit b set.
  localparam logic [23:0] IDX_PAT = {8'hF0, 8'hCC, 8'hAA};

  logic [7:0] lowbit;

  assign lowbit = mask & (~mask + 8'd1);
  assign clr    = lowbit;
  assign multi  = |(mask & (mask - 8'd1));

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_idx
      assign idx[gi] = |(lowbit & IDX_PAT[gi*8 +: 8]);
    end
  endgenerate

endmodule

// File: rtl/lm_sm_sequencer.sv
// Expands LM/SM into per-register LW/SW micro-ops and stalls fetch meanwhile.
// Optional LMSM_PERF_CNT_EN adds a uop_count output counting emitted micro-ops.
module lm_sm_sequencer
  import lm_sm_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] inst_in,
  input  logic [15:0] pc_in,
  input  logic        hold_in,
  input  logic        flush_in,
  output logic [15:0] inst_out,
  output logic [15:0] pc_out,
  output logic        uop_out,
  output logic        uop_last,
  output logic        stall_fetch
`ifdef LMSM_PERF_CNT_EN
  ,
  output logic [15:0] uop_count
`endif
);

  state_t      state_q, state_d;
  logic [7:0]  pending_q, pending_d;
  logic [2:0]  offset_q, offset_d;
  logic [2:0]  ra_q, ra_d;
  logic        is_sm_q, is_sm_d;
  logic [15:0] pc_lat_q, pc_lat_d;
  logic [15:0] inst_out_q, inst_out_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic        uop_out_q, uop_out_d;
  logic        uop_last_q, uop_last_d;

  logic [3:0]  opcode;
  logic        is_lmsm;
  logic [7:0]  pick_mask;
  logic [2:0]  pick_idx;
  logic [7:0]  pick_clr;
  logic        pick_multi;
  logic        kind_sm;
  logic [2:0]  ra_sel;
  logic [2:0]  off_sel;
  logic [15:0] uop_word;

  assign opcode  = inst_in[15:12];
  assign is_lmsm = (opcode == OP_LM) || (opcode == OP_SM);

  // One finder serves both paths: the incoming list in IDLE, the remainder in EXPAND.
  assign pick_mask = (state_q == ST_EXPAND) ? pending_q : inst_in[7:0];

  lsb_pick8 u_pick (
    .mask  (pick_mask),
    .idx   (pick_idx),
    .clr   (pick_clr),
    .multi (pick_multi)
  );

  assign kind_sm  = (state_q == ST_EXPAND) ? is_sm_q  : (opcode == OP_SM);
  assign ra_sel   = (state_q == ST_EXPAND) ? ra_q     : inst_in[11:9];
  assign off_sel  = (state_q == ST_EXPAND) ? offset_q : 3'd0;
  assign uop_word = {(kind_sm ? OP_SW : OP_LW), pick_idx, ra_sel, 3'b000, off_sel};

  // Releases on the cycle the final micro-op is being registered, so no bubble.
  assign stall_fetch = !flush_in && pick_multi && ((state_q == ST_EXPAND) || is_lmsm);

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    offset_d   = offset_q;
    ra_d       = ra_q;
    is_sm_d    = is_sm_q;
    pc_lat_d   = pc_lat_q;
    inst_out_d = inst_out_q;
    pc_out_d   = pc_out_q;
    uop_out_d  = uop_out_q;
    uop_last_d = uop_last_q;

    if (flush_in) begin
      inst_out_d = NOP_WORD;
      uop_out_d  = 1'b0;
      uop_last_d = 1'b0;
      pending_d  = 8'h00;
      offset_d   = 3'd0;
      state_d    = ST_IDLE;
    end else if (!hold_in) begin
      if (state_q == ST_IDLE) begin
        pc_out_d = pc_in;
        if (!is_lmsm) begin
          inst_out_d = inst_in;
          uop_out_d  = 1'b0;
          uop_last_d = 1'b0;
        end else if (inst_in[7:0] == 8'h00) begin
          inst_out_d = NOP_WORD;
          uop_out_d  = 1'b0;
          uop_last_d = 1'b0;
        end else begin
          inst_out_d = uop_word;
          uop_out_d  = 1'b1;
          uop_last_d = !pick_multi;
          pending_d  = inst_in[7:0] & ~pick_clr;
          ra_d       = inst_in[11:9];
          is_sm_d    = (opcode == OP_SM);
          pc_lat_d   = pc_in;
          offset_d   = 3'd1;
          state_d    = pick_multi ? ST_EXPAND : ST_IDLE;
        end
      end else begin
        inst_out_d = uop_word;
        pc_out_d   = pc_lat_q;
        uop_out_d  = 1'b1;
        uop_last_d = !pick_multi;
        pending_d  = pending_q & ~pick_clr;
        offset_d   = offset_q + 3'd1;
        state_d    = pick_multi ? ST_EXPAND : ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pending_q  <= 8'h00;
      offset_q   <= 3'd0;
      ra_q       <= 3'd0;
      is_sm_q    <= 1'b0;
      pc_lat_q   <= 16'h0000;
      inst_out_q <= NOP_WORD;
      pc_out_q   <= 16'h0000;
      uop_out_q  <= 1'b0;
      uop_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      offset_q   <= offset_d;
      ra_q       <= ra_d;
      is_sm_q    <= is_sm_d;
      pc_lat_q   <= pc_lat_d;
      inst_out_q <= inst_out_d;
      pc_out_q   <= pc_out_d;
      uop_out_q  <= uop_out_d;
      uop_last_q <= uop_last_d;
    end
  end

  assign inst_out = inst_out_q;
  assign pc_out   = pc_out_q;
  assign uop_out  = uop_out_q;
  assign uop_last = uop_last_q;

`ifdef LMSM_PERF_CNT_EN
  logic [15:0] uop_count_q, uop_count_d;

  always_comb begin
    uop_count_d = uop_count_q;
    if (!flush_in && !hold_in && uop_out_d)
      uop_count_d = uop_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) uop_count_q <= 16'h0000;
    else     uop_count_q <= uop_count_d;
  end

  assign uop_count = uop_count_q;
`endif

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed, table-driven self-checking bench for lm_sm_sequencer.
module tb_lm_sm_sequencer;

  logic        clk;
  logic        rst;
  logic [15:0] inst_in;
  logic [15:0] pc_in;
  logic        hold_in;
  logic        flush_in;
  logic [15:0] inst_out;
  logic [15:0] pc_out;
  logic        uop_out;
  logic        uop_last;
  logic        stall_fetch;
`ifdef LMSM_PERF_CNT_EN
  logic [15:0] uop_count;
`endif

  int total = 0;
  int bad   = 0;

  lm_sm_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .inst_in     (inst_in),
    .pc_in       (pc_in),
    .hold_in     (hold_in),
    .flush_in    (flush_in),
    .inst_out    (inst_out),
    .pc_out      (pc_out),
    .uop_out     (uop_out),
    .uop_last    (uop_last),
    .stall_fetch (stall_fetch)
`ifdef LMSM_PERF_CNT_EN
    ,
    .uop_count   (uop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One row = one clock: inputs applied, stall_fetch expected before the edge,
  // registered outputs expected after it.
  typedef struct {
    logic [15:0] inst;
    logic [15:0] pc;
    logic        hold;
    logic        flush;
    logic        stall;
    logic [15:0] e_inst;
    logic [15:0] e_pc;
    logic        e_uop;
    logic        e_last;
  } vec_t;

  vec_t vecs[19];

  initial begin
    vecs[0]  = '{16'h1234, 16'h0010, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0010, 1'b0, 1'b0};
    vecs[1]  = '{16'h6225, 16'h0040, 1'b0, 1'b0, 1'b1, 16'h4040, 16'h0040, 1'b1, 1'b0};
    vecs[2]  = '{16'h6225, 16'h0040, 1'b0, 1'b0, 1'b1, 16'h4441, 16'h0040, 1'b1, 1'b0};
    vecs[3]  = '{16'h6225, 16'h0040, 1'b0, 1'b0, 1'b0, 16'h4A42, 16'h0040, 1'b1, 1'b1};
    vecs[4]  = '{16'h7680, 16'h0050, 1'b0, 1'b0, 1'b0, 16'h5EC0, 16'h0050, 1'b1, 1'b1};
    vecs[5]  = '{16'h2345, 16'h0052, 1'b0, 1'b0, 1'b0, 16'h2345, 16'h0052, 1'b0, 1'b0};
    vecs[6]  = '{16'h6200, 16'h0060, 1'b0, 1'b0, 1'b0, 16'hF000, 16'h0060, 1'b0, 1'b0};
    vecs[7]  = '{16'h6225, 16'h0070, 1'b0, 1'b0, 1'b1, 16'h4040, 16'h0070, 1'b1, 1'b0};
    vecs[8]  = '{16'h6225, 16'h0070, 1'b0, 1'b0, 1'b1, 16'h4441, 16'h0070, 1'b1, 1'b0};
    vecs[9]  = '{16'h6225, 16'h0070, 1'b1, 1'b0, 1'b0, 16'h4441, 16'h0070, 1'b1, 1'b0};
    vecs[10] = '{16'h6225, 16'h0070, 1'b1, 1'b0, 1'b0, 16'h4441, 16'h0070, 1'b1, 1'b0};
    vecs[11] = '{16'h6225, 16'h0070, 1'b1, 1'b0, 1'b0, 16'h4441, 16'h0070, 1'b1, 1'b0};
    vecs[12] = '{16'h6225, 16'h0070, 1'b0, 1'b0, 1'b0, 16'h4A42, 16'h0070, 1'b1, 1'b1};
    vecs[13] = '{16'h62FF, 16'h0080, 1'b0, 1'b0, 1'b1, 16'h4040, 16'h0080, 1'b1, 1'b0};
    vecs[14] = '{16'h62FF, 16'h0080, 1'b0, 1'b1, 1'b0, 16'hF000, 16'h0080, 1'b0, 1'b0};
    vecs[15] = '{16'h1234, 16'h0090, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0090, 1'b0, 1'b0};
    vecs[16] = '{16'h62FF, 16'h00A0, 1'b0, 1'b0, 1'b1, 16'h4040, 16'h00A0, 1'b1, 1'b0};
    vecs[17] = '{16'h62FF, 16'h00A0, 1'b1, 1'b1, 1'b0, 16'hF000, 16'h00A0, 1'b0, 1'b0};
    vecs[18] = '{16'h0000, 16'h00B0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h00B0, 1'b0, 1'b0};
  end

  logic [15:0] exp_full[8];

  initial begin
    rst      = 1'b1;
    inst_in  = 16'h0000;
    pc_in    = 16'h0000;
    hold_in  = 1'b0;
    flush_in = 1'b0;

    @(posedge clk);
    #1;
    chk("reset_inst", inst_out, 16'hF000);
    chk("reset_pc",   pc_out,   16'h0000);
    chk("reset_uop",  {15'd0, uop_out},  16'd0);
    chk("reset_last", {15'd0, uop_last}, 16'd0);
    $display("reset: inst_out=%h pc_out=%h uop=%b last=%b", inst_out, pc_out, uop_out, uop_last);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      inst_in  = vecs[i].inst;
      pc_in    = vecs[i].pc;
      hold_in  = vecs[i].hold;
      flush_in = vecs[i].flush;
      #1;
      chk($sformatf("row%0d_stall", i), {15'd0, stall_fetch}, {15'd0, vecs[i].stall});
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_inst", i), inst_out, vecs[i].e_inst);
      chk($sformatf("row%0d_pc", i),   pc_out,   vecs[i].e_pc);
      chk($sformatf("row%0d_uop", i),  {15'd0, uop_out},  {15'd0, vecs[i].e_uop});
      chk($sformatf("row%0d_last", i), {15'd0, uop_last}, {15'd0, vecs[i].e_last});
      $display("row%0d: in=%h h=%b f=%b -> out=%h pc=%h uop=%b last=%b", i,
               vecs[i].inst, vecs[i].hold, vecs[i].flush, inst_out, pc_out, uop_out, uop_last);
    end
    hold_in  = 1'b0;
    flush_in = 1'b0;

    // Async reset between edges in the middle of an expansion.
    inst_in = 16'h62FF;
    pc_in   = 16'h00C0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_inst", inst_out, 16'hF000);
    chk("arst_pc",   pc_out,   16'h0000);
    chk("arst_uop",  {15'd0, uop_out},  16'd0);
    chk("arst_last", {15'd0, uop_last}, 16'd0);
    inst_in = 16'h1234;
    #0.5;
    chk("arst_stall_idle", {15'd0, stall_fetch}, 16'd0);
`ifdef LMSM_PERF_CNT_EN
    chk("arst_count", uop_count, 16'd0);
`endif
    $display("async reset mid-expansion: inst_out=%h pc_out=%h", inst_out, pc_out);
    #0.5;
    rst = 1'b0;

    // Full 8-register expansion: offsets 0..7, last flagged only on R7.
    for (int k = 0; k < 8; k++)
      exp_full[k] = {4'b0100, k[2:0], 3'b001, 3'b000, k[2:0]};
    inst_in = 16'h62FF;
    pc_in   = 16'h00D0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("full%0d_stall", k), {15'd0, stall_fetch}, (k < 7) ? 16'd1 : 16'd0);
      @(posedge clk);
      #1;
      chk($sformatf("full%0d_inst", k), inst_out, exp_full[k]);
      chk($sformatf("full%0d_pc", k),   pc_out,   16'h00D0);
      chk($sformatf("full%0d_last", k), {15'd0, uop_last}, (k == 7) ? 16'd1 : 16'd0);
      $display("full%0d: out=%h pc=%h last=%b", k, inst_out, pc_out, uop_last);
    end
`ifdef LMSM_PERF_CNT_EN
    chk("count_after_full", uop_count, 16'd8);
`endif
    inst_in = 16'h3333;
    pc_in   = 16'h00E0;
    @(posedge clk);
    #1;
    chk("after_full_inst", inst_out, 16'h3333);
    chk("after_full_uop",  {15'd0, uop_out}, 16'd0);
    $display("after full: out=%h uop=%b", inst_out, uop_out);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
